uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares the single UART transmit serializer between NUM_REQ byte producers, for example the CPU MMIO THR write path and a boot/debug monitor.
- Arbitrates producers round-robin into a small byte FIFO.
- A sequencing FSM pops bytes and drives the serializer's DV/active/done handshake, so no producer ever drops a byte while the line is busy.
- Sits between the MMIO UART register block and the uart_tx serializer instance.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- FIFO_DEPTH, 8, FIFO entries (power of two, >=2).
- CNT_W, $clog2(FIFO_DEPTH+1), width of the occupancy count.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_req_valid  input  NUM_REQ  per-requester byte valid
- i_req_data  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k]
- o_req_ready  output  NUM_REQ  one-hot grant/accept; a transfer occurs when valid and ready are both high
- o_tx_dv  output  1  one-cycle start strobe to the serializer
- o_tx_byte  output  8  byte to serialize; held stable from the DV cycle until done
- i_tx_active  input  1  serializer busy
- i_tx_done  input  1  serializer one-cycle completion pulse
- o_fifo_count  output  CNT_W  current FIFO occupancy
- o_busy  output  1  high when the FIFO is non-empty or the FSM is not in IDLE
- o_last_grant  output  $clog2(NUM_REQ) or 1  index of the most recently accepted requester

Behaviour:
- Reset is asynchronous and active-low. All storage and outputs clear on reset:
  - o_tx_dv=0, o_tx_byte=0, o_fifo_count=0, o_busy=0, o_last_grant=0.
  - FSM returns to IDLE.
  - Round-robin pointer resets so requester 0 has top priority.
- Arbitration is combinational from registered state.
  - If FIFO is full: o_req_ready=0.
  - Otherwise: grant the first requester with valid set, searching from (o_last_grant+1) mod NUM_REQ upward.
  - Ready is asserted only to that requester. Zero or one grant per cycle.
- Push: on a granted transfer, the byte is written into the FIFO at the clock edge and o_last_grant updates to the winner. Requesters without a grant hold their data; nothing is dropped.
- Full rule: no push when count==FIFO_DEPTH, even if a pop occurs in the same cycle.
- Empty rule: a byte pushed into an empty FIFO is not poppable until the following cycle.
- Simultaneous push and pop with 0<count<FIFO_DEPTH: count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if count>0 and i_tx_active==0, pop the head into o_tx_byte, pulse o_tx_dv for exactly one cycle, and go to WAIT_DONE.
  - WAIT_DONE: o_tx_dv=0 and o_tx_byte held. On i_tx_done, go to IDLE. i_tx_active is ignored in this state.
  - IDLE re-checks i_tx_active, which absorbs the serializer's cleanup cycle after done.
- Latency:
  - A push at edge N into an empty FIFO with the serializer idle produces o_tx_dv high after edge N+1.
  - Back-to-back: the next DV comes no earlier than the first cycle after done in which i_tx_active==0.
- An i_tx_done arriving while in IDLE (spurious) is ignored.
- Reset mid-transmission:
  - The FIFO is flushed and the FSM returns to IDLE.
  - The serializer has no reset, so the first post-reset DV waits until i_tx_active==0.
- There is no backpressure path other than o_req_ready.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE=1'b0, WAIT_DONE=1'b1).
  - UART_BYTE_W=8.
  - Default FIFO_DEPTH.
- Natural sub-module: uart_byte_fifo (sync FIFO with push/pop/full/empty/count, registered storage, no read-during-write bypass).
- Arbiter and FSM live in the top module.

Test Plan:
1. Reset with i_rst_n=0 while requester 0 is valid with 0x41 -> o_req_ready=0, o_tx_dv=0, count=0. After release, 0x41 is accepted the next cycle, DV pulses one cycle later, and o_tx_byte=0x41.
2. Both requesters continuously valid (req0 sends 0x30..0x33, req1 sends 0x61..0x64) with a serializer model taking 20 cycles per byte -> bytes are emitted interleaved as 0x30,0x61,0x31,0x62,... with no loss.
3. Fill the FIFO with 8 bytes while i_tx_active is stuck at 1 -> count=8 and o_req_ready=0 on all requesters. Release active -> the first DV occurs and the ninth byte is accepted one cycle after the pop.
4. Pulse i_tx_done with i_tx_active held high for 1 extra cycle -> the next DV waits until active falls, and only one DV is issued per byte.
5. Assert reset in WAIT_DONE with count=3 -> count=0 and o_busy=0 immediately. No DV is issued until the model's i_tx_active deasserts.
6. Single requester sending 5 bytes with valid gapped randomly -> FIFO order is preserved, o_last_grant stays 0, and count returns to 0 with o_busy=0 after the final done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and sizes for the UART transmit scheduler slice.
package uart_pkg;
  localparam int UART_BYTE_W        = 8;
  localparam int DEFAULT_FIFO_DEPTH = 8;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_DONE = 1'b1
  } tx_state_e;
endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered storage, count-based full/empty and no read-during-write bypass.
// A byte pushed at an edge is visible at the head one cycle later; push is dropped when full, pop when empty.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [UART_BYTE_W-1:0] i_push_dat,
  input  logic                   i_pop,
  output logic [UART_BYTE_W-1:0] o_head_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [CNT_W-1:0]       o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [UART_BYTE_W-1:0] mem_q [DEPTH];
  logic [UART_BYTE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  assign o_full     = (count_q == CNT_W'(DEPTH));
  assign o_empty    = (count_q == '0);
  assign o_count    = count_q;
  assign o_head_dat = mem_q[rd_ptr_q];
  assign do_push    = i_push && !o_full;
  assign do_pop     = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbitration of NUM_REQ byte producers into a FIFO that feeds one UART serializer.
// Push-to-DV is two edges; producers stall on o_req_ready, which drops while the FIFO is full.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter  int CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int LG_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_tx_dv,
  output logic [UART_BYTE_W-1:0]         o_tx_byte,
  input  logic                           i_tx_active,
  input  logic                           i_tx_done,
  output logic [CNT_W-1:0]               o_fifo_count,
  output logic                           o_busy,
  output logic [LG_W-1:0]                o_last_grant
);
  logic [UART_BYTE_W-1:0] req_byte [NUM_REQ];
  logic [LG_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [LG_W-1:0]        last_grant_q, last_grant_d;
  logic [LG_W-1:0]        cand_idx, win_idx;
  logic [NUM_REQ-1:0]     grant;
  logic                   grant_vld;

  tx_state_e              state_q, state_d;
  logic                   tx_dv_q, tx_dv_d;
  logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;

  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [UART_BYTE_W-1:0] fifo_head;
  logic [CNT_W-1:0]       fifo_count;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = i_req_data[i*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  // rr_ptr_q is the highest-priority index; o_last_grant is kept separately so it can reset to 0.
  always_comb begin
    grant        = '0;
    grant_vld    = 1'b0;
    cand_idx     = '0;
    win_idx      = '0;
    rr_ptr_d     = rr_ptr_q;
    last_grant_d = last_grant_q;
    if (i_rst_n && !fifo_full) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand_idx = LG_W'((int'(rr_ptr_q) + i) % NUM_REQ);
        if (!grant_vld && i_req_valid[cand_idx]) begin
          grant_vld = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
    if (grant_vld) begin
      grant[win_idx] = 1'b1;
      last_grant_d   = win_idx;
      rr_ptr_d       = LG_W'((int'(win_idx) + 1) % NUM_REQ);
    end
  end

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (grant_vld),
    .i_push_dat (req_byte[win_idx]),
    .i_pop      (fifo_pop),
    .o_head_dat (fifo_head),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_count    (fifo_count)
  );

  // IDLE re-samples i_tx_active, which covers the serializer's cleanup cycle after done.
  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !i_tx_active) begin
          fifo_pop  = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = fifo_head;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= '0;
      rr_ptr_q     <= '0;
      last_grant_q <= '0;
    end else begin
      state_q      <= state_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      rr_ptr_q     <= rr_ptr_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign o_req_ready  = grant;
  assign o_tx_dv      = tx_dv_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_fifo_count = fifo_count;
  assign o_busy       = !fifo_empty || (state_q != ST_IDLE);
  assign o_last_grant = last_grant_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural serializer model.
module tb_uart_tx_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active, tx_done;
  logic [3:0]  fifo_count;
  logic        busy;
  logic [0:0]  last_grant;

  logic force_active, man_done;
  logic m_active = 1'b0;
  logic m_done   = 1'b0;
  assign tx_active = m_active | force_active;
  assign tx_done   = m_done | man_done;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(2), .FIFO_DEPTH(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .o_tx_dv      (tx_dv),
    .o_tx_byte    (tx_byte),
    .i_tx_active  (tx_active),
    .i_tx_done    (tx_done),
    .o_fifo_count (fifo_count),
    .o_busy       (busy),
    .o_last_grant (last_grant)
  );

  // Serializer model: busy for mlen cycles after DV, done pulse, then mclean extra active cycles.
  int mlen = 5, mclean = 0;
  int mcnt = 0, mcl = 0, ncyc = 0, viol = 0;
  logic [7:0] emitted [$];
  int dv_ncyc [$];
  int done_ncyc [$];

  always @(negedge clk) begin
    logic cl_act;
    cl_act = 1'b0;
    ncyc++;
    m_done = 1'b0;
    if (tx_dv) begin
      if (tx_active) viol++;
      emitted.push_back(tx_byte);
      dv_ncyc.push_back(ncyc);
      mcnt = mlen;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        m_done = 1'b1;
        mcl    = mclean;
        done_ncyc.push_back(ncyc);
      end
    end else if (mcl > 0) begin
      mcl--;
      cl_act = 1'b1;
    end
    m_active = (mcnt > 0) || m_done || cl_act;
  end

  int total = 0, bad = 0;
  logic [7:0] exp_bytes [$];
  int checked = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    for (c = 0; c < budget; c++) begin
      if (emitted.size() >= exp_bytes.size() && !busy && !tx_active) break;
      tick();
    end
    check({name, "_drain_in_time"}, 32'(c < budget), 32'd1);
  endtask

  task automatic check_stream(input string name);
    int n;
    check({name, "_byte_count"}, emitted.size(), exp_bytes.size());
    n = (emitted.size() < exp_bytes.size()) ? emitted.size() : exp_bytes.size();
    for (int i = checked; i < n; i++) begin
      check($sformatf("%s_byte%0d", name, i - checked), emitted[i], exp_bytes[i]);
    end
    checked = exp_bytes.size();
  endtask

  typedef struct {
    logic [1:0] vld;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] rdy;
    logic [0:0] lg;
    logic [3:0] cnt;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    int idx0, idx1, base_dv, base_done, gap;
    logic [1:0] rdy;

    tbl[0] = '{2'b00, 8'h80, 8'hC0, 2'b00, 1'b0, 4'd0};
    tbl[1] = '{2'b10, 8'h81, 8'hC1, 2'b10, 1'b1, 4'd1};
    tbl[2] = '{2'b11, 8'h82, 8'hC2, 2'b01, 1'b0, 4'd2};
    tbl[3] = '{2'b11, 8'h83, 8'hC3, 2'b10, 1'b1, 4'd3};
    tbl[4] = '{2'b01, 8'h84, 8'hC4, 2'b01, 1'b0, 4'd4};
    tbl[5] = '{2'b01, 8'h85, 8'hC5, 2'b01, 1'b0, 4'd5};
    tbl[6] = '{2'b10, 8'h86, 8'hC6, 2'b10, 1'b1, 4'd6};
    tbl[7] = '{2'b11, 8'h87, 8'hC7, 2'b01, 1'b0, 4'd7};
    tbl[8] = '{2'b11, 8'h88, 8'hC8, 2'b10, 1'b1, 4'd8};
    tbl[9] = '{2'b11, 8'h89, 8'hC9, 2'b00, 1'b1, 4'd8};

    force_active = 1'b0;
    man_done     = 1'b0;
    rst_n        = 1'b0;
    req_valid    = 2'b01;
    req_data     = 16'h0041;

    // 1: reset holds off a valid requester, then first byte flows.
    #2;
    check("t1_rst_ready", req_ready, 2'b00);
    check("t1_rst_dv", tx_dv, 1'b0);
    check("t1_rst_count", fifo_count, 4'd0);
    check("t1_rst_busy", busy, 1'b0);
    check("t1_rst_last_grant", last_grant, 1'b0);
    check("t1_rst_tx_byte", tx_byte, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("t1_ready_after_rst", req_ready, 2'b01);
    tick();
    check("t1_count_after_push", fifo_count, 4'd1);
    check("t1_no_dv_yet", tx_dv, 1'b0);
    req_valid = 2'b00;
    tick();
    check("t1_dv", tx_dv, 1'b1);
    check("t1_tx_byte", tx_byte, 8'h41);
    check("t1_count_after_pop", fifo_count, 4'd0);
    tick();
    check("t1_dv_one_cycle", tx_dv, 1'b0);
    check("t1_byte_held", tx_byte, 8'h41);
    exp_bytes.push_back(8'h41);
    wait_idle("t1", 100);
    check_stream("t1");

    // 2: two continuous producers interleave round-robin.
    do_reset();
    mlen = 20;
    idx0 = 0;
    idx1 = 0;
    for (int c = 0; c < 100 && (idx0 < 4 || idx1 < 4); c++) begin
      req_valid = {1'(idx1 < 4), 1'(idx0 < 4)};
      req_data  = {8'h61 + 8'(idx1), 8'h30 + 8'(idx0)};
      #1;
      rdy = req_ready;
      tick();
      if (rdy[0]) idx0++;
      if (rdy[1]) idx1++;
    end
    req_valid = 2'b00;
    check("t2_producers_done", 32'(idx0 == 4 && idx1 == 4), 32'd1);
    for (int k = 0; k < 4; k++) begin
      exp_bytes.push_back(8'h30 + 8'(k));
      exp_bytes.push_back(8'h61 + 8'(k));
    end
    wait_idle("t2", 400);
    check_stream("t2");

    // 3: table-driven arbitration while the serializer is stuck busy, up to full.
    do_reset();
    mlen = 3;
    force_active = 1'b1;
    for (int r = 0; r < 10; r++) begin
      req_valid = tbl[r].vld;
      req_data  = {tbl[r].d1, tbl[r].d0};
      #1;
      check($sformatf("t3_row%0d_ready", r), req_ready, tbl[r].rdy);
      if (tbl[r].rdy[0]) exp_bytes.push_back(tbl[r].d0);
      if (tbl[r].rdy[1]) exp_bytes.push_back(tbl[r].d1);
      tick();
      check($sformatf("t3_row%0d_count", r), fifo_count, tbl[r].cnt);
      check($sformatf("t3_row%0d_last_grant", r), last_grant, tbl[r].lg);
    end
    req_valid = 2'b01;
    req_data  = 16'h0099;
    #1;
    check("t3_full_no_ready", req_ready, 2'b00);
    force_active = 1'b0;
    tick();
    check("t3_first_dv", tx_dv, 1'b1);
    check("t3_count_after_pop", fifo_count, 4'd7);
    check("t3_ready_after_pop", req_ready, 2'b01);
    tick();
    check("t3_ninth_accepted", fifo_count, 4'd8);
    check("t3_ninth_last_grant", last_grant, 1'b0);
    req_valid = 2'b00;
    exp_bytes.push_back(8'h99);
    wait_idle("t3", 300);
    check_stream("t3");

    // 4: active lingers one cycle after done; next DV waits for it.
    mlen   = 4;
    mclean = 1;
    base_dv   = dv_ncyc.size();
    base_done = done_ncyc.size();
    req_valid = 2'b01;
    req_data  = 16'h0055;
    tick();
    req_data  = 16'h0056;
    tick();
    req_valid = 2'b00;
    exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'h56);
    wait_idle("t4", 100);
    check("t4_dv_count", dv_ncyc.size() - base_dv, 2);
    gap = (dv_ncyc.size() >= base_dv + 2 && done_ncyc.size() > base_done) ?
          dv_ncyc[base_dv+1] - done_ncyc[base_done] : -1;
    check("t4_done_to_dv_gap", gap, 3);
    check_stream("t4");
    mclean = 0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("t4_spurious_done_busy", busy, 1'b0);
    tick();
    check("t4_spurious_done_dv", tx_dv, 1'b0);

    // 5: reset while waiting for done with three bytes queued.
    do_reset();
    mlen = 30;
    req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      req_data = {8'h00, 8'hA0 + 8'(k)};
      tick();
    end
    req_valid = 2'b00;
    check("t5_count_pre", fifo_count, 4'd3);
    check("t5_busy_pre", busy, 1'b1);
    exp_bytes.push_back(8'hA0);
    rst_n = 1'b0;
    #1;
    check("t5_count_in_rst", fifo_count, 4'd0);
    check("t5_busy_in_rst", busy, 1'b0);
    check("t5_tx_byte_in_rst", tx_byte, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    base_dv = dv_ncyc.size();
    req_valid = 2'b01;
    req_data  = 16'h00B0;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("t5_byte_waits", fifo_count, 4'd1);
    check("t5_no_early_dv", dv_ncyc.size() - base_dv, 0);
    exp_bytes.push_back(8'hB0);
    wait_idle("t5", 200);
    check_stream("t5");
    check("t5_no_dv_while_active", viol, 0);

    // 6: single requester with random gaps keeps order and grant index.
    do_reset();
    mlen = 4;
    for (int k = 0; k < 5; k++) begin
      req_valid = 2'b00;
      repeat ($urandom_range(0, 3)) tick();
      req_valid = 2'b01;
      req_data  = {8'h00, 8'h13 + 8'(k * 16)};
      #1;
      check($sformatf("t6_ready%0d", k), req_ready, 2'b01);
      exp_bytes.push_back(8'h13 + 8'(k * 16));
      tick();
      check($sformatf("t6_last_grant%0d", k), last_grant, 1'b0);
    end
    req_valid = 2'b00;
    wait_idle("t6", 200);
    check("t6_final_count", fifo_count, 4'd0);
    check("t6_final_busy", busy, 1'b0);
    check_stream("t6");

    check("no_dv_while_active", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
